// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
//   DATA_BITS         : character width (8N1 framing)
//   CLKS_PER_BIT_DEF  : default bit period in clocks (100 MHz / 115200)
//   rx_state_t        : receiver FSM state encoding
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 868;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream handshake between the UART receiver and its consumer.
//   rx_data  : head byte, meaningful only while rx_valid=1
//   rx_valid : a byte is available
//   rx_ready : consumer takes the byte when rx_valid & rx_ready
// master = byte source (receiver), slave = consumer.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received bytes.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored when full unless pop is also set
//   pop/dout : read request; dout always shows the head entry
//   empty    : no entries
//   full     : DEPTH entries
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra MSB so that equal indices can be told apart
   // as either empty (MSBs equal) or full (MSBs differ).
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // A pop in the same cycle frees the slot, so push-while-full still lands.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   uart_s_in  : asynchronous serial input, idle high
//   rx         : byte stream out (rx_data / rx_valid / rx_ready)
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte dropped because the FIFO was full
//   err_clr    : pulse clearing both sticky flags (a same-cycle set wins)
//   busy       : receiver is inside a frame (FSM not IDLE)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     uart_s_in,
   uart_rx_if.master rx,
   output logic     frame_err,
   output logic     overrun,
   input  logic     err_clr,
   output logic     busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic                 sync1;
   logic                 rx_s;
   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 push;
   logic                 frame_set;
   logic                 pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 ovr_set;

   // Two-flop synchronizer; flops reset to the idle line level so a reset
   // never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= uart_s_in;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_d   = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_HIGH: begin
            // Hold off until the line recovers so a break is one error, not many.
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   assign pop     = rx.rx_valid && rx.rx_ready;
   assign ovr_set = push && fifo_full && !pop;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (sh_q),
      .pop   (pop),
      .dout  (rx.rx_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign rx.rx_valid = !fifo_empty;

   // Sticky flags: set has priority over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (ovr_set)      overrun   <= 1'b1;
         else if (err_clr) overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated bit by bit,
// and a queue-based model of the receiver (bytes received, FIFO capacity,
// sticky flags) supplies every expected value.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic uart_s_in;
   logic err_clr;
   logic frame_err;
   logic overrun;
   logic busy;

   uart_rx_if rxif ();

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_s_in (uart_s_in),
      .rx        (rxif.master),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   logic       exp_ovr = 1'b0;
   logic       exp_ferr = 1'b0;

   // All stimulus is applied just after a falling edge and held for n cycles.
   task automatic drive(input logic v, input int n);
      uart_s_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
   endtask

   // Complete frame, with the model updated from the framing rules.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bits(b);
      drive(stop, CPB);
      if (!stop)                     exp_ferr = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                           exp_ovr = 1'b1;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         n_vec++;
         if (rxif.rx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid[%0d]: got %b want 1", tag, k, rxif.rx_valid);
         end
         n_vec++;
         if (rxif.rx_data !== e) begin
            n_err++;
            $display("FAIL %s_data[%0d]: got %h want %h", tag, k, rxif.rx_data, e);
         end
         rxif.rx_ready = 1'b1;
         @(negedge clk);
         rxif.rx_ready = 1'b0;
         k++;
      end
      n_vec++;
      if (rxif.rx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_empty: rx_valid got %b want 0", tag, rxif.rx_valid);
      end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr  = 1'b0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
   endtask

   task automatic check_flags(input string tag);
      n_vec++;
      if (overrun !== exp_ovr) begin
         n_err++;
         $display("FAIL %s_overrun: got %b want %b", tag, overrun, exp_ovr);
      end
      n_vec++;
      if (frame_err !== exp_ferr) begin
         n_err++;
         $display("FAIL %s_frame_err: got %b want %b", tag, frame_err, exp_ferr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      uart_s_in = 1'b1;
      err_clr = 1'b0;
      rxif.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 100);
      n_vec++;
      if (rxif.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rxif.rx_valid); end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++;
      if (rxif.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rxif.rx_data); end
      check_flags("reset");
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1);
      drive(1'b1, 2);
      drain("single");
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [4];
      pat = '{8'h01, 8'h80, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) send_frame(pat[i], 1'b1);
      drive(1'b1, 2);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b want 0", busy); end
      drain("b2b");
   endtask

   task automatic test_overrun();
      logic [7:0] pat [5];
      pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h3C};
      for (int i = 0; i < 5; i++) send_frame(pat[i], 1'b1);
      drive(1'b1, 2);
      check_flags("ovr_set");
      drain("ovr");
      pulse_clr();
      check_flags("ovr_clr");
   endtask

   task automatic test_frame_err();
      send_bits(8'h55);
      drive(1'b0, CPB);
      exp_ferr = 1'b1;
      drive(1'b0, 40);
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low: got %b want 1", busy); end
      check_flags("ferr_set");
      n_vec++;
      if (rxif.rx_valid !== 1'b0) begin n_err++; $display("FAIL ferr_nopush: rx_valid got %b want 0", rxif.rx_valid); end
      drive(1'b1, 5);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_high: got %b want 0", busy); end
      send_frame(8'h12, 1'b1);
      drive(1'b1, 2);
      drain("ferr_next");
      check_flags("ferr_sticky");
      pulse_clr();
      check_flags("ferr_clr");
   endtask

   task automatic test_glitch();
      drive(1'b0, 3);
      drive(1'b1, 20);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
      n_vec++;
      if (rxif.rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_push: rx_valid got %b want 0", rxif.rx_valid); end
      check_flags("glitch");
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'hC3;
      send_frame(8'h99, 1'b1);
      drive(1'b1, 2);
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      drive(b[4], CPB/2);
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
      rst = 1'b1;
      uart_s_in = 1'b1;
      #1;
      exp_q.delete();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
      n_vec++;
      if (rxif.rx_valid !== 1'b0) begin n_err++; $display("FAIL mid_fifo_rst: rx_valid got %b want 0", rxif.rx_valid); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 10);
      send_frame(b, 1'b1);
      drive(1'b1, 2);
      drain("mid_next");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) send_frame(8'($urandom), 1'b1);
         drive(1'b1, $urandom_range(2, 6));
         check_flags("rnd");
         drain("rnd");
         pulse_clr();
         check_flags("rnd_clr");
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
